// File: rtl/vga_led_regs.sv
// vga_led_regs
// ------------
// Bus-facing register bank for the VGA seven-segment emulator. Software
// writes eight digit shadow registers plus a hex-decode mask through a
// simple Avalon-MM style slave. Shadows are copied to the hex0..hex7
// outputs only on the falling edge of vertical sync, or one cycle after a
// force-commit write. This keeps the display from changing mid-frame.
//
// Ports:
//   clk50       system clock, shared with the emulator
//   reset_n     asynchronous active-low reset
//   chipselect  slave select; qualifies write and read
//   write       write strobe
//   read        read strobe (readdata valid on the next edge)
//   address     register index 0..15
//   writedata   write data
//   readdata    registered read data; holds between reads
//   vga_vs      active-low vertical sync from the emulator (same clock)
//   hex0..hex7  committed segment patterns: bit0=a .. bit6=g, bit7=dp,
//               1 = lit
//
// Register map:
//   0-7   digit shadow N
//   8     decode mask shadow (bit N=1 hex-decodes digit N)
//   9     write bit0=1 forces a commit; read returns {7'b0, pending}
//   10    blink mask shadow (blink build only; otherwise unmapped)
//   11-15 unmapped: read 0, writes ignored
//
// Optional feature (macro VGA_LED_BLINK_EN):
//   Register 10 becomes a committed blink mask. A BLINK_DIV_LOG2-bit frame
//   counter advances on every vsync falling edge. While its MSB is set,
//   every digit whose committed blink bit is set is driven as 0x00.

module vga_led_regs #(
  parameter int BLINK_DIV_LOG2 = 5
) (
  input  logic       clk50,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [3:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       vga_vs,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5,
  output logic [7:0] hex6,
  output logic [7:0] hex7
);

  // A counter of zero width is meaningless, so an invalid divider setting
  // produces a visibly named block in the elaborated hierarchy.
  if (BLINK_DIV_LOG2 < 1) begin : g_blink_div_invalid
  end

  // Seven-segment patterns for hex digits 0-F (bit0=a .. bit6=g).
  function automatic logic [6:0] hexdec(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [7:0][7:0] shadow_q;
  logic [7:0]      decode_q;
  logic [7:0][7:0] committed_q;
  logic [7:0][7:0] committed_next;
  logic [7:0][7:0] hex_q;
  logic [7:0][7:0] hex_next;
  logic [7:0]      rd_mux;
  logic            pending_q;
  logic            force_q;
  logic            vs_d;
  logic            wr_en;
  logic            rd_en;
  logic            shadow_wr;
  logic            frame_edge;
  logic            commit;

  assign wr_en      = chipselect & write;
  assign rd_en      = chipselect & read;
  assign frame_edge = vs_d & ~vga_vs;
  // force_q is set by the reg 9 write itself, so a forced commit happens
  // one cycle after that write.
  assign commit     = frame_edge | force_q;

`ifdef VGA_LED_BLINK_EN
  logic [7:0]                blink_shadow_q;
  logic [7:0]                blink_commit_q;
  logic [7:0]                blink_commit_next;
  logic [BLINK_DIV_LOG2-1:0] frame_cnt_q;
  logic                      blink_phase;

  assign shadow_wr = wr_en & ((address <= 4'd8) | (address == 4'd10));
  assign blink_commit_next = commit ? blink_shadow_q : blink_commit_q;
  assign blink_phase = frame_cnt_q[BLINK_DIV_LOG2-1];

  // The blink mask is shadowed and committed exactly like the digits. The
  // frame counter counts vsync edges only, so forced commits do not
  // disturb the blink rhythm.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      blink_shadow_q <= '0;
      blink_commit_q <= '0;
      frame_cnt_q    <= '0;
    end else begin
      if (wr_en && address == 4'd10) begin
        blink_shadow_q <= writedata;
      end
      blink_commit_q <= blink_commit_next;
      if (frame_edge) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end
`else
  assign shadow_wr = wr_en & (address <= 4'd8);
`endif

  // Commit target for each digit. The value is computed from the current
  // shadow, so a write landing on the same edge as a commit is left for the
  // next commit.
  always_comb begin
    committed_next = committed_q;
    if (commit) begin
      for (int n = 0; n < 8; n++) begin
        if (decode_q[n]) begin
          committed_next[n] = {shadow_q[n][7], hexdec(shadow_q[n][3:0])};
        end else begin
          committed_next[n] = shadow_q[n];
        end
      end
    end
  end

  // The output register loads the commit target directly, so a commit is
  // visible on the edge that performs it. Blink gating uses the registered
  // counter MSB. A phase change therefore shows up one cycle after the
  // counter moves.
  always_comb begin
    hex_next = committed_next;
`ifdef VGA_LED_BLINK_EN
    for (int n = 0; n < 8; n++) begin
      if (blink_phase && blink_commit_next[n]) begin
        hex_next[n] = 8'h00;
      end
    end
`endif
  end

  // Read mux. Digit reads return shadows, not what is on the display.
  always_comb begin
    rd_mux = 8'h00;
    if (!address[3]) begin
      rd_mux = shadow_q[address[2:0]];
    end else begin
      case (address)
        4'd8:    rd_mux = decode_q;
        4'd9:    rd_mux = {7'b0, pending_q};
`ifdef VGA_LED_BLINK_EN
        4'd10:   rd_mux = blink_shadow_q;
`endif
        default: rd_mux = 8'h00;
      endcase
    end
  end

  // Shadow registers and the force request. Force is a one-cycle pulse.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      decode_q <= '0;
      force_q  <= 1'b0;
    end else begin
      if (wr_en && !address[3]) begin
        shadow_q[address[2:0]] <= writedata;
      end
      if (wr_en && address == 4'd8) begin
        decode_q <= writedata;
      end
      force_q <= wr_en && (address == 4'd9) && writedata[0];
    end
  end

  // Pending: a shadow write wins over a simultaneous commit because that
  // commit used the pre-write shadow.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= shadow_wr | (pending_q & ~commit);
    end
  end

  // Vsync edge detector. It resets high so that a sync already low when
  // reset is released is not mistaken for a new frame.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      vs_d <= 1'b1;
    end else begin
      vs_d <= vga_vs;
    end
  end

  // Committed values, the display output register and read data.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      committed_q <= '0;
      hex_q       <= '0;
      readdata    <= 8'h00;
    end else begin
      committed_q <= committed_next;
      hex_q       <= hex_next;
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];

endmodule

// File: tb/tb_vga_led_regs.sv
// tb_vga_led_regs
// ---------------
// Directed, self-checking bench for vga_led_regs. Inputs change 1 ns after
// a rising edge, and outputs are sampled at the same point. The blink
// section is compiled only when VGA_LED_BLINK_EN is defined.

module tb_vga_led_regs;

  logic       clk50;
  logic       reset_n;
  logic       chipselect;
  logic       write;
  logic       read;
  logic [3:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       vga_vs;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int checks;
  int failures;

  vga_led_regs #(.BLINK_DIV_LOG2(2)) dut (
    .clk50      (clk50),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .vga_vs     (vga_vs),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5),
    .hex6       (hex6),
    .hex7       (hex7)
  );

  // 50 MHz clock.
  initial begin
    clk50 = 1'b0;
    forever #10 clk50 = ~clk50;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                               input logic [3:0] addr, input logic [7:0] data,
                               input logic vs);
    chipselect = cs;
    write      = wr;
    read       = rd;
    address    = addr;
    writedata  = data;
    vga_vs     = vs;
    @(posedge clk50);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
  endtask

  task automatic busWrite(input logic [3:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, data, 1'b1);
  endtask

  task automatic busRead(input logic [3:0] addr, output logic [7:0] data);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, 8'h00, 1'b1);
    data = readdata;
  endtask

  // vga_vs low for one cycle. Returns just after the commit edge.
  task automatic vsyncFall();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] rd;
    checks     = 0;
    failures   = 0;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = 4'd0;
    writedata  = 8'h00;
    vga_vs     = 1'b1;
    reset_n    = 1'b1;

    // Reset state
    #3 reset_n = 1'b0;
    #2;
    checkOutput("reset hex0", hex0, 8'h00);
    checkOutput("reset hex3", hex3, 8'h00);
    checkOutput("reset hex7", hex7, 8'h00);
    checkOutput("reset readdata", readdata, 8'h00);
    @(negedge clk50);
    @(negedge clk50);
    reset_n = 1'b1;
    idle();
    busRead(4'd9, rd);
    checkOutput("reg9 after reset", rd, 8'h00);

    // Raw digit committed on the vsync falling edge
    busWrite(4'd0, 8'h5B);
    busRead(4'd0, rd);
    checkOutput("reg0 shadow readback", rd, 8'h5B);
    checkOutput("hex0 before vsync", hex0, 8'h00);
    busRead(4'd9, rd);
    checkOutput("pending after write", rd, 8'h01);
    vsyncFall();
    checkOutput("hex0 after vsync", hex0, 8'h5B);
    idle();
    busRead(4'd9, rd);
    checkOutput("pending after commit", rd, 8'h00);

    // Decoded digit with dp: 0x8A -> dp + 'A' = 0xF7
    busWrite(4'd8, 8'h02);
    busWrite(4'd1, 8'h8A);
    busRead(4'd1, rd);
    checkOutput("reg1 shadow readback", rd, 8'h8A);
    vsyncFall();
    checkOutput("hex1 decoded", hex1, 8'hF7);
    checkOutput("hex0 kept", hex0, 8'h5B);
    idle();

    // Force commit with vsync high: visible two cycles after the reg 9 write
    busWrite(4'd2, 8'h3F);
    busWrite(4'd9, 8'h01);
    checkOutput("hex2 one cycle after force", hex2, 8'h00);
    idle();
    checkOutput("hex2 two cycles after force", hex2, 8'h3F);
    busRead(4'd9, rd);
    checkOutput("pending after force", rd, 8'h00);

    // Reg 9 write with bit0=0 must not commit
    busWrite(4'd2, 8'h00);
    busWrite(4'd9, 8'h02);
    idle();
    idle();
    checkOutput("hex2 no force", hex2, 8'h3F);
    busRead(4'd9, rd);
    checkOutput("pending kept", rd, 8'h01);

    // Write coincident with frame edge: commit sees the old shadow
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 8'h06, 1'b0);
    checkOutput("hex3 same-cycle write", hex3, 8'h00);
    checkOutput("hex2 committed old shadow", hex2, 8'h00);
    idle();
    busRead(4'd9, rd);
    checkOutput("pending after race", rd, 8'h01);
    vsyncFall();
    checkOutput("hex3 next frame", hex3, 8'h06);
    idle();
    busRead(4'd9, rd);
    checkOutput("pending cleared", rd, 8'h00);

    // Unmapped registers
    busWrite(4'd12, 8'hFF);
    busRead(4'd12, rd);
    checkOutput("reg12 reads 0", rd, 8'h00);
    busRead(4'd9, rd);
    checkOutput("no pending from reg12", rd, 8'h00);
`ifndef VGA_LED_BLINK_EN
    busWrite(4'd10, 8'hFF);
    busRead(4'd10, rd);
    checkOutput("reg10 unmapped", rd, 8'h00);
    busRead(4'd9, rd);
    checkOutput("no pending from reg10", rd, 8'h00);
`endif

    // Decode mask change: digit 7 0xF9 -> dp + '9' = 0xEF; digit 1 raw again
    busWrite(4'd8, 8'h80);
    busWrite(4'd7, 8'hF9);
    busWrite(4'd9, 8'h01);
    idle();
    checkOutput("hex7 decoded", hex7, 8'hEF);
    checkOutput("hex1 raw", hex1, 8'h8A);
    checkOutput("hex0 still", hex0, 8'h5B);

    // readdata holds between reads; read+write same cycle returns old value
    busRead(4'd7, rd);
    checkOutput("reg7 readback", rd, 8'hF9);
    idle();
    busWrite(4'd0, 8'h22);
    idle();
    checkOutput("readdata holds", readdata, 8'hF9);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h11, 1'b1);
    checkOutput("read during write old", readdata, 8'h22);
    busRead(4'd0, rd);
    checkOutput("reg0 new value", rd, 8'h11);
    checkOutput("hex0 not committed", hex0, 8'h5B);

    // Asynchronous reset mid-cycle
    idle();
    #5 reset_n = 1'b0;
    #1;
    checkOutput("async reset hex0", hex0, 8'h00);
    checkOutput("async reset hex7", hex7, 8'h00);
    checkOutput("async reset readdata", readdata, 8'h00);
    @(negedge clk50);
    reset_n = 1'b1;
    idle();
    busRead(4'd0, rd);
    checkOutput("shadow0 cleared", rd, 8'h00);
    busRead(4'd9, rd);
    checkOutput("pending cleared by reset", rd, 8'h00);

`ifdef VGA_LED_BLINK_EN
    // Blink with a 2-bit counter: on 2 frames, off 2 frames
    begin
      logic [7:0] blink_exp [5];
      blink_exp = '{8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7F};
      busWrite(4'd4, 8'h7F);
      busWrite(4'd10, 8'h10);
      busRead(4'd10, rd);
      checkOutput("reg10 readback", rd, 8'h10);
      for (int k = 0; k < 5; k++) begin
        vsyncFall();
        idle();
        checkOutput($sformatf("hex4 blink frame %0d", k + 1), hex4, blink_exp[k]);
      end
      #5 reset_n = 1'b0;
      #1;
      checkOutput("hex4 reset mid-blink", hex4, 8'h00);
      @(negedge clk50);
      reset_n = 1'b1;
      idle();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
